// File: rtl/counter_sequencer.sv
// Run/pause/step sequencer for the 4-bit count-and-display path: owns the
// count register and tick prescaler, driven by edges of debounced key levels.
module counter_sequencer #(
  parameter int unsigned SIZE     = 4,
  parameter int unsigned PRESCALE = 50000000
) (
  input  logic            clock_pos,
  input  logic            reset_neg,
  input  logic            signal_start,
  input  logic            signal_stop,
  input  logic            signal_load,
  input  logic [SIZE-1:0] vector_load,
  input  logic            bit_up,
  input  logic            bit_wrap,
  output logic [SIZE-1:0] vector_out,
  output logic            signal_tick,
  output logic            signal_terminal,
  output logic [1:0]      vector_state
);

  localparam int unsigned     PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [SIZE-1:0] MAX_COUNT  = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [SIZE-1:0] count_q, count_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            tick_q, tick_d;
  logic            term_q, term_d;
  logic            start_q, stop_q, load_q;

  logic start_e, stop_e, load_e;
  logic tick_due, at_term;

  assign start_e  = signal_start & ~start_q;
  assign stop_e   = signal_stop  & ~stop_q;
  assign load_e   = signal_load  & ~load_q;
  assign tick_due = (presc_q == PRESC_LAST);
  assign at_term  = bit_up ? (count_q == MAX_COUNT) : (count_q == '0);

  // Edge registers reset high so a key already held at release is not an edge.
  always_ff @(posedge clock_pos or negedge reset_neg) begin
    if (!reset_neg) begin
      state_q <= IDLE;
      count_q <= '0;
      presc_q <= '0;
      tick_q  <= 1'b0;
      term_q  <= 1'b0;
      start_q <= 1'b1;
      stop_q  <= 1'b1;
      load_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      term_q  <= term_d;
      start_q <= signal_start;
      stop_q  <= signal_stop;
      load_q  <= signal_load;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (!stop_e && start_e) state_d = RUN;
      end
      RUN: begin
        if (stop_e)                                   state_d = PAUSE;
        else if (tick_due && at_term && !bit_wrap)    state_d = DONE;
      end
      PAUSE: begin
        if (stop_e)       state_d = IDLE;
        else if (start_e) state_d = RUN;
      end
      DONE: begin
        if (stop_e)       state_d = IDLE;
        else if (start_e) state_d = RUN;
        else if (load_e)  state_d = PAUSE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stop wins over start, start over load; a stop in RUN holds the prescaler
  // and swallows any tick due on that edge.
  always_comb begin
    count_d = count_q;
    presc_d = presc_q;
    tick_d  = 1'b0;
    term_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!stop_e) begin
          if (start_e)     presc_d = '0;
          else if (load_e) count_d = vector_load;
        end
      end
      RUN: begin
        if (!stop_e) begin
          if (tick_due) begin
            presc_d = '0;
            tick_d  = 1'b1;
            if (at_term) begin
              term_d = 1'b1;
              if (bit_wrap) count_d = bit_up ? '0 : MAX_COUNT;
            end else begin
              count_d = bit_up ? count_q + 1'b1 : count_q - 1'b1;
            end
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
      end
      PAUSE: begin
        if (stop_e)                 count_d = '0;
        else if (!start_e && load_e) count_d = vector_load;
      end
      DONE: begin
        if (stop_e) begin
          count_d = '0;
        end else if (start_e) begin
          count_d = bit_up ? '0 : MAX_COUNT;
          presc_d = '0;
        end else if (load_e) begin
          count_d = vector_load;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    vector_out      = count_q;
    vector_state    = state_q;
    signal_tick     = tick_q;
    signal_terminal = term_q;
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// Scoreboard bench for counter_sequencer: stimulus queues expected output
// events (with the cycle they must appear in); a monitor pops and compares.
module tb_counter_sequencer;

  logic       clk = 1'b0;
  logic       reset_neg;
  logic       signal_start, signal_stop, signal_load;
  logic [3:0] vector_load;
  logic       bit_up, bit_wrap;
  logic [3:0] vector_out;
  logic       signal_tick, signal_terminal;
  logic [1:0] vector_state;

  always #5 clk = ~clk;

  counter_sequencer #(.SIZE(4), .PRESCALE(4)) dut (
    .clock_pos      (clk),
    .reset_neg      (reset_neg),
    .signal_start   (signal_start),
    .signal_stop    (signal_stop),
    .signal_load    (signal_load),
    .vector_load    (vector_load),
    .bit_up         (bit_up),
    .bit_wrap       (bit_wrap),
    .vector_out     (vector_out),
    .signal_tick    (signal_tick),
    .signal_terminal(signal_terminal),
    .vector_state   (vector_state)
  );

  typedef struct {
    logic [1:0] st;
    logic [3:0] out;
    logic       tk;
    logic       tm;
    int         at;
    string      tag;
  } exp_t;

  exp_t       sbq[$];
  exp_t       mon_e;
  exp_t       left_e;
  int         cyc        = 0;
  int         n_cmp      = 0;
  int         n_bad      = 0;
  int         force_cnt  = 0;
  int         force_seen = 0;
  logic [5:0] prev_key   = '0;
  int         base;

  always @(posedge clk) cyc++;

  task automatic expect_ev(input logic [1:0] st, input logic [3:0] out,
                           input logic tk, input logic tm, input int at,
                           input string tag);
    exp_t e;
    e.st = st; e.out = out; e.tk = tk; e.tm = tm; e.at = at; e.tag = tag;
    sbq.push_back(e);
  endtask

  // Immediate, clock-independent sample of the outputs.
  task automatic fcheck(input logic [1:0] st, input logic [3:0] out, input string tag);
    expect_ev(st, out, 1'b0, 1'b0, cyc, tag);
    force_cnt++;
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // An output event is a change of state/count, any pulse high, or a forced sample.
  always begin
    @(negedge clk or force_cnt);
    if (force_cnt != force_seen ||
        (reset_neg && ({vector_state, vector_out} != prev_key ||
                       signal_tick || signal_terminal))) begin
      force_seen = force_cnt;
      n_cmp++;
      if (sbq.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_event: got st=%0d out=%0d tick=%0b term=%0b cyc=%0d, required no event",
                 vector_state, vector_out, signal_tick, signal_terminal, cyc);
      end else begin
        mon_e = sbq.pop_front();
        if (vector_state !== mon_e.st || vector_out !== mon_e.out ||
            signal_tick !== mon_e.tk || signal_terminal !== mon_e.tm || cyc != mon_e.at) begin
          n_bad++;
          $display("FAIL %s: got st=%0d out=%0d tick=%0b term=%0b cyc=%0d, required st=%0d out=%0d tick=%0b term=%0b cyc=%0d",
                   mon_e.tag, vector_state, vector_out, signal_tick, signal_terminal, cyc,
                   mon_e.st, mon_e.out, mon_e.tk, mon_e.tm, mon_e.at);
        end
      end
    end
    prev_key = {vector_state, vector_out};
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000ns, required finish");
    $fatal(1);
  end

  initial begin
    reset_neg = 1'b0; signal_start = 1'b0; signal_stop = 1'b0; signal_load = 1'b0;
    vector_load = '0; bit_up = 1'b1; bit_wrap = 1'b1;

    // Reset held with inputs toggling, then released with start already high
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      signal_start = 1'($urandom_range(0, 1));
      signal_stop  = 1'($urandom_range(0, 1));
      signal_load  = 1'($urandom_range(0, 1));
      vector_load  = 4'($urandom_range(0, 15));
    end
    @(negedge clk); #2;
    fcheck(2'd0, 4'd0, "reset_hold");
    @(negedge clk);
    signal_start = 1'b1; signal_stop = 1'b0; signal_load = 1'b0;
    reset_neg = 1'b1;
    repeat (3) @(negedge clk);
    #2 fcheck(2'd0, 4'd0, "release_start_held");
    @(negedge clk); signal_start = 1'b0;

    // Up count with wrap, then pause/resume
    @(negedge clk);
    signal_start = 1'b1; base = cyc;
    expect_ev(2'd1, 4'd0, 1'b0, 1'b0, base + 1, "run_entry");
    for (int k = 1; k <= 17; k++)
      expect_ev(2'd1, 4'(k % 16), 1'b1, (k == 16), base + 1 + 4 * k,
                (k == 16) ? "up_wrap" : "up_tick");
    @(negedge clk); signal_start = 1'b0;
    wait_until(base + 71);
    signal_stop = 1'b1;
    expect_ev(2'd2, 4'd1, 1'b0, 1'b0, base + 72, "pause");
    @(negedge clk); signal_stop = 1'b0;
    wait_until(base + 78);
    #2 fcheck(2'd2, 4'd1, "pause_frozen");
    wait_until(base + 82);
    signal_start = 1'b1;
    expect_ev(2'd1, 4'd1, 1'b0, 1'b0, base + 83, "resume");
    expect_ev(2'd1, 4'd2, 1'b1, 1'b0, base + 85, "resume_tick");
    @(negedge clk); signal_start = 1'b0;
    wait_until(base + 86);
    signal_stop = 1'b1;
    expect_ev(2'd2, 4'd2, 1'b0, 1'b0, base + 87, "stop_to_pause");
    @(negedge clk); signal_stop = 1'b0;
    @(negedge clk); signal_stop = 1'b1;
    expect_ev(2'd0, 4'd0, 1'b0, 1'b0, base + 89, "stop_to_idle");
    @(negedge clk); signal_stop = 1'b0;

    // Load, count down, halt in DONE, restart from max
    @(negedge clk);
    signal_load = 1'b1; vector_load = 4'd3;
    expect_ev(2'd0, 4'd3, 1'b0, 1'b0, cyc + 1, "load_idle");
    @(negedge clk); signal_load = 1'b0; bit_up = 1'b0; bit_wrap = 1'b0;
    @(negedge clk);
    signal_start = 1'b1; base = cyc;
    expect_ev(2'd1, 4'd3, 1'b0, 1'b0, base + 1,  "run_down");
    expect_ev(2'd1, 4'd2, 1'b1, 1'b0, base + 5,  "down_tick2");
    expect_ev(2'd1, 4'd1, 1'b1, 1'b0, base + 9,  "down_tick1");
    expect_ev(2'd1, 4'd0, 1'b1, 1'b0, base + 13, "down_tick0");
    expect_ev(2'd3, 4'd0, 1'b1, 1'b1, base + 17, "done_halt");
    @(negedge clk); signal_start = 1'b0;
    wait_until(base + 20);
    signal_start = 1'b1;
    expect_ev(2'd1, 4'd15, 1'b0, 1'b0, base + 21, "restart_down");
    @(negedge clk); signal_start = 1'b0;
    wait_until(base + 22);
    signal_load = 1'b1; vector_load = 4'd9;
    @(negedge clk); signal_load = 1'b0;
    wait_until(base + 24);
    #2 fcheck(2'd1, 4'd15, "load_ignored_run");
    expect_ev(2'd1, 4'd14, 1'b1, 1'b0, base + 25, "restart_tick");
    wait_until(base + 26);
    signal_start = 1'b1; signal_stop = 1'b1;
    expect_ev(2'd2, 4'd14, 1'b0, 1'b0, base + 27, "startstop_run");
    @(negedge clk); signal_start = 1'b0; signal_stop = 1'b0;
    @(negedge clk); signal_stop = 1'b1;
    expect_ev(2'd0, 4'd0, 1'b0, 1'b0, base + 29, "pause_clear");
    @(negedge clk); signal_stop = 1'b0;
    @(negedge clk); signal_start = 1'b1; signal_stop = 1'b1;
    @(negedge clk); signal_start = 1'b0; signal_stop = 1'b0;
    wait_until(base + 33);
    #2 fcheck(2'd0, 4'd0, "startstop_idle");

    // Async reset mid-RUN at count 9
    bit_up = 1'b1; bit_wrap = 1'b1;
    @(negedge clk);
    signal_load = 1'b1; vector_load = 4'd8;
    expect_ev(2'd0, 4'd8, 1'b0, 1'b0, cyc + 1, "load8");
    @(negedge clk); signal_load = 1'b0;
    @(negedge clk);
    signal_start = 1'b1; base = cyc;
    expect_ev(2'd1, 4'd8, 1'b0, 1'b0, base + 1, "run_from8");
    expect_ev(2'd1, 4'd9, 1'b1, 1'b0, base + 5, "tick_to9");
    @(negedge clk); signal_start = 1'b0;
    wait_until(base + 6);
    #2 reset_neg = 1'b0;
    #1 fcheck(2'd0, 4'd0, "async_reset");
    repeat (2) @(negedge clk);
    reset_neg = 1'b1;
    repeat (4) @(negedge clk);

    while (sbq.size() > 0) begin
      left_e = sbq.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got no event, required st=%0d out=%0d tick=%0b term=%0b cyc=%0d",
               left_e.tag, left_e.st, left_e.out, left_e.tk, left_e.tm, left_e.at);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
